// File: rtl/fir_pkg.sv
// Shared constants for the FIR coefficient/sample loader: default sizes,
// FSM state encoding and the underrun counter width.
package fir_pkg;
  localparam int FIR_W1 = 9;
  localparam int FIR_L  = 15;
  localparam int UND_W  = 16;

  typedef logic [1:0] state_t;
  localparam state_t COLLECT = 2'd0;
  localparam state_t BURST   = 2'd1;
  localparam state_t FLUSH   = 2'd2;
  localparam state_t RUN     = 2'd3;
endpackage

// File: rtl/fir_coef_bank.sv
// L x W1 coefficient register file: one synchronous write port and one
// asynchronous read port. Contents are not reset.
module fir_coef_bank #(
  parameter int W1 = 9,
  parameter int L  = 15,
  localparam int IW = $clog2(L)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [IW-1:0] widx_i,
  input  logic [W1-1:0] wdata_i,
  input  logic [IW-1:0] ridx_i,
  output logic [W1-1:0] rdata_o
);
  logic [L-1:0][W1-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[widx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[ridx_i];
endmodule

// File: rtl/fir_load_ctrl.sv
// Collects L coefficients, bursts them into the FIR, flushes the sample line,
// then streams samples. Optional underrun counter: FIR_LOAD_UNDERRUN_CNT_EN.
module fir_load_ctrl import fir_pkg::*; #(
  parameter int W1 = FIR_W1,
  parameter int L  = FIR_L
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          coef_valid,
  input  logic [W1-1:0] coef_data,
  output logic          coef_ready,
  input  logic          samp_valid,
  input  logic [W1-1:0] samp_data,
  output logic          samp_ready,
  input  logic          reload,
  output logic          Load_x,
  output logic [W1-1:0] x_in,
  output logic [W1-1:0] c_in,
  output logic          running
`ifdef FIR_LOAD_UNDERRUN_CNT_EN
  ,
  output logic [UND_W-1:0] underrun_cnt
`endif
);
  localparam int IW = $clog2(L);
  localparam logic [IW-1:0] LAST  = IW'(L-1);
  localparam logic [IW-1:0] FLAST = IW'(L-2);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          load_q, load_d, run_q, run_d;
  logic [W1-1:0] x_q, x_d, c_q, c_d, bank_rd;
  logic          coef_hs, samp_hs;

  assign coef_hs = coef_valid && coef_ready;
  assign samp_hs = samp_valid && samp_ready;

  // Read at idx_d so c_in lands in the same cycle the FSM shows BURST.
  fir_coef_bank #(.W1(W1), .L(L)) u_bank (
    .clk     (clk),
    .we_i    (coef_hs),
    .widx_i  (idx_q),
    .wdata_i (coef_data),
    .ridx_i  (idx_d),
    .rdata_o (bank_rd)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      load_q  <= 1'b1;
      x_q     <= '0;
      c_q     <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      load_q  <= load_d;
      x_q     <= x_d;
      c_q     <= c_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      COLLECT: begin
        if (reload) idx_d = '0;
        else if (coef_hs) begin
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = BURST;
          end else idx_d = idx_q + 1'b1;
        end
      end
      BURST: begin
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = FLUSH;
        end else idx_d = idx_q + 1'b1;
      end
      FLUSH: begin
        if (idx_q == FLAST) begin
          idx_d   = '0;
          state_d = RUN;
        end else idx_d = idx_q + 1'b1;
      end
      RUN: begin
        if (reload) begin
          idx_d   = '0;
          state_d = COLLECT;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = COLLECT;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_comb begin
    coef_ready = (state_q == COLLECT) && reset && !reload;
    samp_ready = (state_q == RUN) && reset && !reload;
    load_d     = (state_d != BURST);
    run_d      = (state_d == RUN);
    c_d        = (state_d == BURST) ? bank_rd : c_q;
    x_d        = samp_hs ? samp_data : '0;
  end

  assign Load_x  = load_q;
  assign x_in    = x_q;
  assign c_in    = c_q;
  assign running = run_q;

`ifdef FIR_LOAD_UNDERRUN_CNT_EN
  logic [UND_W-1:0] und_q;

  always_ff @(posedge clk) begin
    if (!reset)                                         und_q <= '0;
    else if (state_d == COLLECT)                        und_q <= '0;
    else if (state_q == RUN && !samp_valid && und_q != '1) und_q <= und_q + 1'b1;
  end

  assign underrun_cnt = und_q;
`endif
endmodule
